// File: rtl/soc_system_st_channel_filter_adapter.sv
// soc_system_st_channel_filter_adapter
// Avalon-ST channel adapter: narrows in_channel to a sink with MAX_CHANNEL+1
// channels and filters whole packets by the channel carried on their SOP beat.
// Out-of-range packets are consumed and discarded SOP to EOP. Forwarded beats
// pass through one output register backed by a one-entry skid, so in_ready is
// registered and never depends combinationally on out_ready.
//
// Optional feature macro: ST_CHANNEL_FILTER_DROP_COUNT_EN
//   defined     -> drop_count counts dropped packets, saturating at all-ones
//   not defined -> drop_count is tied to 0
//
// Ports
//   clk, reset_n                 clock, async active-low reset
//   in_ready/in_valid/in_data/in_channel/in_startofpacket/in_endofpacket
//                                upstream Avalon-ST sink side
//   out_ready/out_valid/out_data/out_channel/out_startofpacket/out_endofpacket
//                                downstream Avalon-ST source side
//   drop_count                   dropped-packet count
module soc_system_st_channel_filter_adapter #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned IN_CH_W     = 8,
  parameter int unsigned OUT_CH_W    = 1,
  parameter int unsigned MAX_CHANNEL = 0,
  parameter int unsigned DROP_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CH_W-1:0]    in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CH_W-1:0]   out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [DROP_CNT_W-1:0] drop_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PASS = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  localparam logic [IN_CH_W-1:0] MAX_CH = IN_CH_W'(MAX_CHANNEL);

  typedef struct packed {
    logic                sop;
    logic                eop;
    logic [OUT_CH_W-1:0] ch;
    logic [DATA_W-1:0]   data;
  } beat_t;

  logic [1:0]          state_q;
  logic [1:0]          state_d;
  logic [OUT_CH_W-1:0] ch_q;
  logic                skid_valid_q;
  beat_t               skid_q;
  beat_t               out_q;

  logic                accept_c;
  logic                in_range_c;
  logic                fwd_c;
  logic                load_c;
  logic                skid_nxt_c;
  beat_t               in_beat_c;

  assign accept_c   = in_valid & in_ready;
  assign in_range_c = (in_channel <= MAX_CH);
  assign load_c     = ~out_valid | out_ready;

  // Mid-packet beats reuse the channel latched from their SOP beat.
  assign in_beat_c.sop  = in_startofpacket;
  assign in_beat_c.eop  = in_endofpacket;
  assign in_beat_c.ch   = in_startofpacket ? in_channel[OUT_CH_W-1:0] : ch_q;
  assign in_beat_c.data = in_data;

  // Skid holds a beat only if one arrives while the output is stalled;
  // while it is full in_ready is low, so it never has to take a second.
  assign skid_nxt_c = load_c ? (skid_valid_q & fwd_c) : (skid_valid_q | fwd_c);

  // Packet state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Packet next-state and forward decision; an SOP always restarts evaluation.
  always_comb begin
    state_d = state_q;
    fwd_c   = 1'b0;
    if (accept_c) begin
      if (in_startofpacket) begin
        if (in_range_c) begin
          fwd_c   = 1'b1;
          state_d = in_endofpacket ? IDLE : PASS;
        end else begin
          state_d = in_endofpacket ? IDLE : DROP;
        end
      end else begin
        case (state_q)
          PASS: begin
            fwd_c = 1'b1;
            if (in_endofpacket) state_d = IDLE;
          end
          DROP: begin
            if (in_endofpacket) state_d = IDLE;
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Channel latch, ready, skid and output register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_q         <= '0;
      in_ready     <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      out_valid    <= 1'b0;
      out_q        <= '0;
    end else begin
      if (accept_c && in_startofpacket && in_range_c) ch_q <= in_channel[OUT_CH_W-1:0];
      in_ready     <= ~skid_nxt_c;
      skid_valid_q <= skid_nxt_c;
      if (load_c) begin
        if (skid_valid_q) begin
          out_valid <= 1'b1;
          out_q     <= skid_q;
          if (fwd_c) skid_q <= in_beat_c;
        end else begin
          out_valid <= fwd_c;
          if (fwd_c) out_q <= in_beat_c;
        end
      end else if (fwd_c) begin
        skid_q <= in_beat_c;
      end
    end
  end

  assign out_data          = out_q.data;
  assign out_channel       = out_q.ch;
  assign out_startofpacket = out_q.sop;
  assign out_endofpacket   = out_q.eop;

`ifdef ST_CHANNEL_FILTER_DROP_COUNT_EN
  logic drop_sop_c;

  // A packet counts as dropped when its out-of-range SOP beat is consumed.
  assign drop_sop_c = accept_c & in_startofpacket & ~in_range_c;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      drop_count <= '0;
    else if (drop_sop_c && (drop_count != {DROP_CNT_W{1'b1}}))
      drop_count <= drop_count + DROP_CNT_W'(1);
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: tb/tb_soc_system_st_channel_filter_adapter.sv
// Directed bench for soc_system_st_channel_filter_adapter (MAX_CHANNEL=0,
// DROP_CNT_W=2). Output beats are collected by a monitor and compared in order
// against hand-built expected beat lists.
module tb_soc_system_st_channel_filter_adapter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [0:0] out_channel;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [1:0] drop_count;

  int n_vec = 0;
  int n_err = 0;
  int n_drop = 0;
  int rdy_low = 0;
  bit watch_rdy = 1'b0;
  logic [31:0] rx[$];
  logic [31:0] ex[$];

  soc_system_st_channel_filter_adapter #(
    .DATA_W(8), .IN_CH_W(8), .OUT_CH_W(1), .MAX_CHANNEL(0), .DROP_CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .in_channel(in_channel), .in_startofpacket(in_startofpacket),
    .in_endofpacket(in_endofpacket),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_channel(out_channel), .out_startofpacket(out_startofpacket),
    .out_endofpacket(out_endofpacket), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Capture each beat the sink takes (transfer happens on the next posedge).
  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready)
      rx.push_back({21'd0, out_startofpacket, out_endofpacket, out_channel, out_data});
    if (watch_rdy && !in_ready) rdy_low++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bt(input logic sop, input logic eop, input logic ch,
                                     input logic [7:0] d);
    return {21'd0, sop, eop, ch, d};
  endfunction

  function automatic logic [31:0] exp_drop(input int n);
`ifdef ST_CHANNEL_FILTER_DROP_COUNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return (n > 3) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one beat and hold it until accepted; returns 1 time unit after the accepting edge.
  task automatic send(input logic [7:0] d, input logic [7:0] ch, input logic sop, input logic eop);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data = d;
    in_channel = ch;
    in_startofpacket = sop;
    in_endofpacket = eop;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    if (!done) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_startofpacket = 1'b0;
    in_endofpacket = 1'b0;
  endtask

  task automatic cmp_q(input string tag);
    int n;
    repeat (4) tick();
    check({tag, "_count"}, 32'(rx.size()), 32'(ex.size()));
    n = (rx.size() < ex.size()) ? rx.size() : ex.size();
    for (int i = 0; i < n; i++) check(tag, rx[i], ex[i]);
    rx.delete();
    ex.delete();
  endtask

  initial begin
    time t0;
    reset_n = 1'b0;
    out_ready = 1'b1;
    in_data = '0;
    in_channel = '0;
    idle();

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_beat", bt(out_startofpacket, out_endofpacket, out_channel, out_data), 32'd0);
    check("rst_drop", 32'(drop_count), 32'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_ready_hold", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("rst_ready_up", 32'(in_ready), 32'd1);
    tick();

    // 1: ch0 4-beat packet, 1-cycle latency, full throughput
    check("t1_idle_valid", 32'(out_valid), 32'd0);
    send(8'h11, 8'd0, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    check("t1_latency_valid", 32'(out_valid), 32'd1);
    check("t1_latency_beat", bt(out_startofpacket, out_endofpacket, out_channel, out_data),
          bt(1'b1, 1'b0, 1'b0, 8'h11));
    tick();
    t0 = $time;
    send(8'h12, 8'd0, 1'b0, 1'b0);
    send(8'h13, 8'd0, 1'b0, 1'b0);
    send(8'h14, 8'd0, 1'b0, 1'b1);
    check("t1_rate_cycles", 32'(($time - t0) / 10), 32'd3);
    idle();
    ex.push_back(bt(1'b1, 1'b0, 1'b0, 8'h11));
    ex.push_back(bt(1'b0, 1'b0, 1'b0, 8'h12));
    ex.push_back(bt(1'b0, 1'b0, 1'b0, 8'h13));
    ex.push_back(bt(1'b0, 1'b1, 1'b0, 8'h14));
    cmp_q("t1_beat");

    // 2: ch3 packet dropped, then ch0 single beat; stray non-SOP ignored
    watch_rdy = 1'b1;
    send(8'h31, 8'd3, 1'b1, 1'b0);
    send(8'h32, 8'd0, 1'b0, 1'b0);
    send(8'h33, 8'd0, 1'b0, 1'b1);
    send(8'h99, 8'd0, 1'b0, 1'b1);
    send(8'hA5, 8'd0, 1'b1, 1'b1);
    idle();
    n_drop++;
    watch_rdy = 1'b0;
    check("t2_ready_low_cycles", 32'(rdy_low), 32'd0);
    check("t2_drop", 32'(drop_count), exp_drop(n_drop));
    ex.push_back(bt(1'b1, 1'b1, 1'b0, 8'hA5));
    cmp_q("t2_beat");

    // 3: backpressure into the skid, then release
    send(8'h21, 8'd0, 1'b1, 1'b0);
    out_ready = 1'b0;
    send(8'h22, 8'd0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t3_stall_ready", 32'(in_ready), 32'd0);
      check("t3_stall_hold", bt(out_startofpacket, out_endofpacket, {out_valid}, out_data),
            bt(1'b1, 1'b0, 1'b1, 8'h21));
    end
    tick();
    out_ready = 1'b1;
    send(8'h23, 8'd0, 1'b0, 1'b0);
    send(8'h24, 8'd0, 1'b0, 1'b1);
    idle();
    ex.push_back(bt(1'b1, 1'b0, 1'b0, 8'h21));
    ex.push_back(bt(1'b0, 1'b0, 1'b0, 8'h22));
    ex.push_back(bt(1'b0, 1'b0, 1'b0, 8'h23));
    ex.push_back(bt(1'b0, 1'b1, 1'b0, 8'h24));
    cmp_q("t3_beat");

    // 4: unterminated ch0 packet followed by SOP on ch2
    send(8'h41, 8'd0, 1'b1, 1'b0);
    send(8'h42, 8'd0, 1'b0, 1'b0);
    send(8'h43, 8'd2, 1'b1, 1'b0);
    send(8'h44, 8'd0, 1'b0, 1'b1);
    idle();
    n_drop++;
    check("t4_drop", 32'(drop_count), exp_drop(n_drop));
    ex.push_back(bt(1'b1, 1'b0, 1'b0, 8'h41));
    ex.push_back(bt(1'b0, 1'b0, 1'b0, 8'h42));
    cmp_q("t4_beat");

    // 5: five more dropped packets, counter saturates
    send(8'h51, 8'd5, 1'b1, 1'b1); n_drop++;
    check("t5_drop_a", 32'(drop_count), exp_drop(n_drop));
    send(8'h52, 8'd1, 1'b1, 1'b1); n_drop++;
    check("t5_drop_b", 32'(drop_count), exp_drop(n_drop));
    send(8'h53, 8'd9, 1'b1, 1'b0);
    send(8'h54, 8'd0, 1'b0, 1'b1); n_drop++;
    check("t5_drop_c", 32'(drop_count), exp_drop(n_drop));
    send(8'h55, 8'd128, 1'b1, 1'b1); n_drop++;
    send(8'h56, 8'd255, 1'b1, 1'b1); n_drop++;
    idle();
    check("t5_drop_sat", 32'(drop_count), exp_drop(n_drop));
    cmp_q("t5_beat");

    // 6: reset mid-packet with a held output beat
    out_ready = 1'b0;
    send(8'h61, 8'd0, 1'b1, 1'b0);
    send(8'h62, 8'd0, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    check("t6_pre_valid", 32'(out_valid), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'd0);
    check("t6_rst_ready", 32'(in_ready), 32'd0);
    check("t6_rst_beat", bt(out_startofpacket, out_endofpacket, out_channel, out_data), 32'd0);
    n_drop = 0;
    check("t6_rst_drop", 32'(drop_count), exp_drop(n_drop));
    rx.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_ready_hold", 32'(in_ready), 32'd0);
    tick();
    send(8'h63, 8'd0, 1'b0, 1'b0);
    send(8'h64, 8'd0, 1'b0, 1'b1);
    send(8'h65, 8'd0, 1'b1, 1'b1);
    idle();
    check("t6_drop", 32'(drop_count), exp_drop(n_drop));
    ex.push_back(bt(1'b1, 1'b1, 1'b0, 8'h65));
    cmp_q("t6_beat");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
